// File: rtl/avalon_out_pio_handshake_if.sv
// Bus and fabric-side signals of the output PIO: Avalon-MM slave port plus the
// valid/ready stream towards the fabric consumer.
interface avalon_out_pio_handshake_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            address;
    logic                  chipselect;
    logic                  write;
    logic                  read;
    logic [31:0]           writedata;
    logic [31:0]           readdata;
    logic [DATA_WIDTH-1:0] out_port;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  address, chipselect, write, read, writedata, out_ready,
        output readdata, out_port, out_valid
    );

    modport master (
        output address, chipselect, write, read, writedata, out_ready,
        input  readdata, out_port, out_valid
    );
endinterface

// File: rtl/avalon_out_pio_handshake.sv
// Avalon-MM output PIO: CPU-written word is presented to the fabric with a valid/ready handshake.
// Optional OUT_PIO_IRQ_EN adds an irq output and an irq_en bit in STATUS.
module avalon_out_pio_handshake #(
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] RESET_VALUE = '0,
    parameter int          OVR_W       = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    avalon_out_pio_handshake_if.slave    bus
`ifdef OUT_PIO_IRQ_EN
    ,
    output logic                         irq
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_SET    = 2'd1;
    localparam logic [1:0] ADDR_CLEAR  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    state_t                state;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  out_valid_q;
    logic [OVR_W-1:0]      ovr_cnt;
    logic                  irq_pend;
    logic [31:0]           readdata_q;

    logic                  wr;
    logic                  rd;
    logic                  data_wr;
    logic                  status_wr;
    logic                  accept;
    logic                  ovr_inc;
    logic                  ovr_clr;
    logic                  irq_pend_nxt;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic [31:0]           status_word;
    logic [31:0]           rd_mux;

`ifdef OUT_PIO_IRQ_EN
    logic irq_en;
    logic irq_en_nxt;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned -- otherwise synthesis infers a latch.
    always_comb begin
        wr        = bus.chipselect & bus.write;
        rd        = bus.chipselect & bus.read & ~wr;
        data_wr   = wr & (bus.address != ADDR_STATUS);
        status_wr = wr & (bus.address == ADDR_STATUS);
        accept    = (state == PEND) & bus.out_ready;
        wd        = bus.writedata[DATA_WIDTH-1:0];

        data_nxt = data_q;
        case (bus.address)
            ADDR_DATA:  data_nxt = wd;
            ADDR_SET:   data_nxt = data_q | wd;
            ADDR_CLEAR: data_nxt = data_q & ~wd;
            default:    data_nxt = data_q;
        endcase

        // Overwrite of a value the fabric has not taken; an accept on the same edge is not an overrun.
        ovr_inc = data_wr & (state == PEND) & ~bus.out_ready;
        ovr_clr = status_wr & bus.writedata[2];

        irq_pend_nxt = irq_pend;
        if (status_wr && bus.writedata[1]) irq_pend_nxt = 1'b0;
        if (accept)                        irq_pend_nxt = 1'b1;

`ifdef OUT_PIO_IRQ_EN
        irq_en_nxt = status_wr ? bus.writedata[3] : irq_en;
`endif

        status_word              = '0;
        status_word[0]           = out_valid_q;
        status_word[1]           = irq_pend;
`ifdef OUT_PIO_IRQ_EN
        status_word[3]           = irq_en;
`endif
        status_word[8 +: OVR_W]  = ovr_cnt;

        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:   rd_mux = 32'(data_q);
            ADDR_STATUS: rd_mux = status_word;
            default:     rd_mux = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            data_q      <= RESET_VALUE[DATA_WIDTH-1:0];
            ovr_cnt     <= '0;
            irq_pend    <= 1'b0;
            readdata_q  <= '0;
`ifdef OUT_PIO_IRQ_EN
            irq_en      <= 1'b0;
            irq         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (data_wr) begin
                        state       <= PEND;
                        out_valid_q <= 1'b1;
                    end
                end
                PEND: begin
                    if (accept && !data_wr) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase

            if (data_wr) data_q <= data_nxt;

            if (ovr_clr)
                ovr_cnt <= '0;
            else if (ovr_inc && (ovr_cnt != '1))
                ovr_cnt <= ovr_cnt + OVR_W'(1);

            irq_pend   <= irq_pend_nxt;
            readdata_q <= rd ? rd_mux : '0;
`ifdef OUT_PIO_IRQ_EN
            irq_en     <= irq_en_nxt;
            irq        <= irq_pend_nxt & irq_en_nxt;
`endif
        end
    end

    assign bus.out_port  = data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.readdata  = readdata_q;

endmodule

// File: tb/tb_avalon_out_pio_handshake.sv
// Directed scoreboard bench for avalon_out_pio_handshake (default parameters).
// Define OUT_PIO_IRQ_EN for both bench and RTL to exercise the irq option.
module tb_avalon_out_pio_handshake;

    logic clk;
    logic reset_n;
`ifdef OUT_PIO_IRQ_EN
    logic irq;
`endif

    avalon_out_pio_handshake_if #(.DATA_WIDTH(32)) bus ();

    avalon_out_pio_handshake #(
        .DATA_WIDTH  (32),
        .RESET_VALUE (32'h0),
        .OVR_W       (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef OUT_PIO_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_item_t;

    sb_item_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic push_exp(input string tag, input logic [31:0] val);
        sb_item_t item;
        item.tag = tag;
        item.val = val;
        sb.push_back(item);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        sb_item_t item;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=0x%08h expected=<entry>", obs);
        end else begin
            item = sb.pop_front();
            assert (obs === item.val) else begin
                errors++;
                $error("FAIL %s observed=0x%08h expected=0x%08h", item.tag, obs, item.val);
            end
        end
    endtask

    task automatic expect_now(input string tag, input logic [31:0] exp, input logic [31:0] obs);
        push_exp(tag, exp);
        pop_check(obs);
    endtask

    // Strobes are driven on the falling edge, so the write lands on the following rising edge.
    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = addr;
        bus.writedata  = data;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        push_exp(tag, exp);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = addr;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        pop_check(bus.readdata);
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.writedata  = '0;
        bus.out_ready  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        expect_now("rst_out_port",  32'h0, bus.out_port);
        expect_now("rst_out_valid", 32'h0, 32'(bus.out_valid));
        expect_now("rst_readdata",  32'h0, bus.readdata);
        reset_n = 1'b1;
        bus_read("rst_status", 2'd3, 32'h0);

        // Write with fabric ready: valid for one cycle, accept sets irq_pend
        bus.out_ready = 1'b1;
        bus_write(2'd0, 32'h1234_5678);
        expect_now("wr_out_port",   32'h1234_5678, bus.out_port);
        expect_now("wr_valid_high", 32'h1, 32'(bus.out_valid));
        @(negedge clk);
        expect_now("wr_valid_low",  32'h0, 32'(bus.out_valid));
        expect_now("wr_port_hold",  32'h1234_5678, bus.out_port);
        bus_read("accept_status", 2'd3, 32'h0000_0002);
        bus_write(2'd3, 32'h6);

        // Overwrite without accept counts an overrun
        bus.out_ready = 1'b0;
        bus_write(2'd0, 32'hA);
        bus_write(2'd0, 32'hB);
        expect_now("ovr_out_port",  32'hB, bus.out_port);
        expect_now("ovr_valid",     32'h1, 32'(bus.out_valid));
        bus_read("ovr_status", 2'd3, 32'h0000_0101);
        bus_write(2'd3, 32'h4);
        bus_read("ovr_cleared", 2'd3, 32'h0000_0001);
        for (int i = 0; i < 300; i++) bus_write(2'd0, 32'(i));
        bus_read("ovr_saturate", 2'd3, 32'h0000_FF01);
        expect_now("ovr_last_data", 32'd299, bus.out_port);

        // SET / CLEAR on a still-pending value
        bus_write(2'd0, 32'h0);
        bus_write(2'd1, 32'h0F);
        expect_now("set_port",   32'h0F, bus.out_port);
        bus_write(2'd2, 32'h03);
        expect_now("clear_port", 32'h0C, bus.out_port);
        bus_read("read_set_addr",   2'd1, 32'h0);
        bus_read("read_clear_addr", 2'd2, 32'h0);
        bus_read("read_data_addr",  2'd0, 32'h0C);
        @(negedge clk);
        expect_now("readdata_idle", 32'h0, bus.readdata);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        expect_now("late_accept_valid", 32'h0, 32'(bus.out_valid));
        expect_now("late_accept_port",  32'h0C, bus.out_port);
        bus_write(2'd3, 32'h6);
        bus_read("status_all_clear", 2'd3, 32'h0);

        // Accept and new write on the same edge: old value consumed, new one pending, no overrun
        bus_write(2'd0, 32'h5);
        expect_now("same_pend_port", 32'h5, bus.out_port);
        @(negedge clk);
        bus.out_ready  = 1'b1;
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = 32'h6;
        expect_now("consumer_sample", 32'h5, bus.out_port);
        expect_now("consumer_valid",  32'h1, 32'(bus.out_valid));
        @(negedge clk);
        bus.out_ready  = 1'b0;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        expect_now("same_edge_port",  32'h6, bus.out_port);
        expect_now("same_edge_valid", 32'h1, 32'(bus.out_valid));
        bus_read("same_edge_status", 2'd3, 32'h0000_0003);

        // Asynchronous reset while a value is pending
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        expect_now("async_rst_valid", 32'h0, 32'(bus.out_valid));
        expect_now("async_rst_port",  32'h0, bus.out_port);
        expect_now("async_rst_rdata", 32'h0, bus.readdata);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read("async_rst_status", 2'd3, 32'h0);

`ifdef OUT_PIO_IRQ_EN
        bus_write(2'd3, 32'h8);
        bus_write(2'd0, 32'h1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        expect_now("irq_set", 32'h1, 32'(irq));
        bus_write(2'd3, 32'hA);
        expect_now("irq_ack", 32'h0, 32'(irq));
        bus_read("irq_en_status", 2'd3, 32'h0000_0008);
        bus_write(2'd3, 32'h0);
        bus_write(2'd0, 32'h2);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        expect_now("irq_masked", 32'h0, 32'(irq));
        bus_read("irq_masked_status", 2'd3, 32'h0000_0002);
`else
        bus_write(2'd3, 32'h8);
        bus_read("no_irq_en_bit", 2'd3, 32'h0);
`endif

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
